e_mdu_ctrl: RTL
===============

Name: e_mdu_ctrl

Overview:
- Execute-stage multiply/divide sequencer for the five-stage MIPS pipeline.
- Owns the HI/LO register pair and models multi-cycle latency for mult/multu/div/divu. Executes mthi/mtlo writes.
- Drives `busy` so hazard logic can stall any MDU-class instruction held in Decode.
- Sits beside the Execute ALU. Operands arrive already forwarded; the opcode comes from the controller.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1).
- DIV_CYCLES, 10, busy cycles for div/divu (>=1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  one-cycle pulse: issue the op on `mdu_op` this cycle.
- mdu_op  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 7 reserved, treated as NONE.
- req  input  1  exception/interrupt cancel; when 1, this cycle's start is ignored.
- rs  input  32  operand A (dividend / multiplicand / mt source).
- rt  input  32  operand B (divisor / multiplier).
- busy  output  1  registered; high while a mult/div is in flight.
- hi  output  32  architectural HI.
- lo  output  32  architectural LO.

Behaviour:
- Reset (reset==0 at an edge): state=IDLE, busy=0, hi=0, lo=0, counter=0, pending results=0. Reset mid-operation aborts the op and discards its result.
- Accept rule: an op is accepted at an edge only when start==1, req==0, and state==IDLE. Otherwise start is ignored; no error flag is raised.
- Upstream guarantee: the stall logic uses (start|busy) and never issues while busy.
- MTHI/MTLO when accepted: hi<=rs (or lo<=rs) at that edge. No busy cycle. State stays IDLE.
- MULT/MULTU/DIV/DIVU when accepted:
  - Compute the result from rs/rt at the accept edge and latch it into pending registers.
  - Load counter with N (MULT_CYCLES or DIV_CYCLES). Go to BUSY. busy=1 from the next cycle.
- BUSY: counter decrements each edge. At the edge where counter goes 1->0: commit pending to hi/lo, busy<=0, return to IDLE.
- Timing: busy is high for exactly N cycles. New hi/lo are visible in the first cycle after busy falls. hi/lo hold their old values throughout BUSY.
- start in the same cycle busy falls is ignored, because busy is still 1 that cycle. The next IDLE cycle accepts.
- Arithmetic:
  - MULT: signed 32x32->64; hi=prod[63:32], lo=prod[31:0].
  - MULTU: unsigned; same split.
  - DIV: signed, truncating toward zero; lo=quotient, hi=remainder, remainder sign = dividend sign.
  - DIVU: unsigned.
- Division by zero (rt==0): the op still takes DIV_CYCLES with busy high. hi/lo are left unchanged at commit.
- Signed overflow (0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0.
- req during BUSY has no effect. An in-flight op always completes, since its instruction has already passed Execute.
- Reserved opcode 7 and NONE with start=1 are accepted as no-ops: no state change, no busy.

Decomposition:
- Shared package/header: MDU_OP_* opcode constants (3-bit); default MULT_CYCLES/DIV_CYCLES; IDLE/BUSY state encoding. The Decode-stage controller and hazard unit use the same constants.
- One sub-module is natural: e_mdu_arith, purely combinational. It takes op, rs, rt and returns {res_hi, res_lo, div_zero}. It isolates the signed/unsigned and overflow rules so they can be unit-tested.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles, release -> busy=0, hi=0, lo=0 persist with start=0.
- MULT signed: rs=0xFFFFFFFE (-2), rt=3, start -> busy high exactly 5 cycles; afterwards hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV sign/overflow: rs=-7, rt=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero: preload hi=0x11, lo=0x22 via MTHI/MTLO (each visible next cycle, busy stays 0); DIVU rt=0 -> busy 10 cycles, hi=0x11, lo=0x22 unchanged.
- Ignored starts:
  - start with req=1 -> no busy, hi/lo unchanged.
  - start MTHI during BUSY -> hi unaffected; the in-flight result commits normally.
  - start on the last busy cycle -> ignored.
- Reset mid-op: start DIV, assert reset on busy cycle 4 -> next cycle busy=0, hi=lo=0; no later commit occurs.

Source files
------------

// File: rtl/e_mdu_ctrl_pkg.sv
// e_mdu_ctrl_pkg
// Shared definitions for the Execute-stage multiply/divide unit. The Decode
// controller and hazard unit use the same opcode constants, so any change
// here affects all three blocks.
//   MDU_OP_*      : 3-bit opcode carried on mdu_op
//   MDU_*_DEF     : default busy latencies for the long-running ops
//   mdu_state_t   : sequencer state encoding (IDLE / BUSY)
package e_mdu_ctrl_pkg;

    localparam logic [2:0] MDU_OP_NONE  = 3'd0;
    localparam logic [2:0] MDU_OP_MULT  = 3'd1;
    localparam logic [2:0] MDU_OP_MULTU = 3'd2;
    localparam logic [2:0] MDU_OP_DIV   = 3'd3;
    localparam logic [2:0] MDU_OP_DIVU  = 3'd4;
    localparam logic [2:0] MDU_OP_MTHI  = 3'd5;
    localparam logic [2:0] MDU_OP_MTLO  = 3'd6;

    localparam int MDU_MULT_CYCLES_DEF = 5;
    localparam int MDU_DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_t;

    // True for the ops that occupy the unit for several cycles.
    function automatic logic is_mdu_long(input logic [2:0] op);
        return (op == MDU_OP_MULT) || (op == MDU_OP_MULTU) ||
               (op == MDU_OP_DIV)  || (op == MDU_OP_DIVU);
    endfunction

endpackage

// File: rtl/e_mdu_arith.sv
// e_mdu_arith
// Purely combinational result generator for mult/multu/div/divu.
//   op       : mdu opcode (only MULT/MULTU/DIV/DIVU produce results)
//   rs, rt   : operands (dividend/multiplicand, divisor/multiplier)
//   res_hi   : product[63:32] or remainder
//   res_lo   : product[31:0]  or quotient
//   div_zero : divide op with rt == 0; the caller must not commit
module e_mdu_arith
    import e_mdu_ctrl_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_zero
);

    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] prod;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] den;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    // One 64-bit multiplier serves both forms: the low 64 bits of a product
    // of sign-extended operands equal the signed 32x32 product.
    assign ext_a = (op == MDU_OP_MULT) ? {{32{rs[31]}}, rs} : {32'b0, rs};
    assign ext_b = (op == MDU_OP_MULT) ? {{32{rt[31]}}, rt} : {32'b0, rt};
    assign prod  = ext_a * ext_b;

    // Signed division runs on magnitudes. 0x80000000 / -1 needs no special
    // case: magnitude 0x80000000 negates back to itself with remainder 0.
    assign neg_a = (op == MDU_OP_DIV) && rs[31];
    assign neg_b = (op == MDU_OP_DIV) && rt[31];
    assign mag_a = neg_a ? (32'd0 - rs) : rs;
    assign mag_b = neg_b ? (32'd0 - rt) : rt;
    assign den   = (rt == 32'd0) ? 32'd1 : mag_b;
    assign q_mag = mag_a / den;
    assign r_mag = mag_a % den;
    // Truncation toward zero: remainder takes the dividend's sign.
    assign quot  = (neg_a ^ neg_b) ? (32'd0 - q_mag) : q_mag;
    assign rem   = neg_a ? (32'd0 - r_mag) : r_mag;

    always_comb begin
        res_hi   = 32'd0;
        res_lo   = 32'd0;
        div_zero = 1'b0;
        case (op)
            MDU_OP_MULT, MDU_OP_MULTU: begin
                res_hi = prod[63:32];
                res_lo = prod[31:0];
            end
            MDU_OP_DIV, MDU_OP_DIVU: begin
                res_hi   = rem;
                res_lo   = quot;
                div_zero = (rt == 32'd0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/e_mdu_ctrl.sv
// e_mdu_ctrl
// Execute-stage multiply/divide sequencer. Owns HI/LO, applies mthi/mtlo
// immediately and models the multi-cycle latency of mult/div.
//   clk, reset  : clock; synchronous active-low reset
//   start       : issue pulse for mdu_op this cycle
//   mdu_op      : opcode (MDU_OP_*; 7 behaves as NONE)
//   req         : exception cancel, suppresses this cycle's start
//   rs, rt      : forwarded operands
//   busy        : high for exactly N cycles after a mult/div is accepted
//   hi, lo      : architectural HI/LO
//
// Issue handshake: an op is taken at a rising edge iff start=1, req=0 and
// the unit is idle (busy=0). start while busy=1, including the cycle in
// which busy is about to fall, is silently dropped; upstream stalls on
// (start|busy) so it never relies on that. Results become visible in the
// first cycle with busy=0 after the op.
module e_mdu_ctrl
    import e_mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdu_op,
    input  logic        req,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_t       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [31:0]      pend_hi, pend_hi_n;
    logic [31:0]      pend_lo, pend_lo_n;
    logic             pend_wr, pend_wr_n;
    logic [31:0]      hi_n, lo_n;

    logic [31:0]      res_hi, res_lo;
    logic             div_zero;
    logic             accept;

    e_mdu_arith u_arith (
        .op       (mdu_op),
        .rs       (rs),
        .rt       (rt),
        .res_hi   (res_hi),
        .res_lo   (res_lo),
        .div_zero (div_zero)
    );

    assign accept = start && !req && (state == MDU_IDLE);
    // Derived straight from the state register, so busy is glitch-free.
    assign busy   = (state == MDU_BUSY);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= MDU_IDLE;
            cnt     <= '0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            pend_hi <= pend_hi_n;
            pend_lo <= pend_lo_n;
            pend_wr <= pend_wr_n;
            hi      <= hi_n;
            lo      <= lo_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        pend_hi_n = pend_hi;
        pend_lo_n = pend_lo;
        pend_wr_n = pend_wr;
        hi_n      = hi;
        lo_n      = lo;
        case (state)
            MDU_IDLE: begin
                if (accept) begin
                    if (mdu_op == MDU_OP_MTHI) begin
                        hi_n = rs;
                    end else if (mdu_op == MDU_OP_MTLO) begin
                        lo_n = rs;
                    end else if (is_mdu_long(mdu_op)) begin
                        pend_hi_n = res_hi;
                        pend_lo_n = res_lo;
                        // Divide by zero still burns its cycles but never commits.
                        pend_wr_n = !div_zero;
                        state_n   = MDU_BUSY;
                        if ((mdu_op == MDU_OP_MULT) || (mdu_op == MDU_OP_MULTU)) begin
                            cnt_n = CNT_W'(MULT_CYCLES);
                        end else begin
                            cnt_n = CNT_W'(DIV_CYCLES);
                        end
                    end
                end
            end
            MDU_BUSY: begin
                cnt_n = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_n   = MDU_IDLE;
                    pend_wr_n = 1'b0;
                    if (pend_wr) begin
                        hi_n = pend_hi;
                        lo_n = pend_lo;
                    end
                end
            end
            default: state_n = MDU_IDLE;
        endcase
    end

endmodule
